tmds_decoder: RTL and testbench

//  Receive-side TMDS channel decoder; the inverse of the DVI transmitter's per-channel encoder.
//  - Takes one deserialized 10-bit symbol per pixel clock.
//  - Finds the 10-bit word boundary by hunting for control tokens.
//  - Decodes the aligned symbol into 8-bit pixel data or a 2-bit control code, plus DE.
//  - Sits between a 1:10 deserializer and the DVI receiver video output, one instance per channel.

---
 rtl/tmds_decoder.sv | 199 +++++++++++++++++++
 tb/tb_tmds_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: finds the word boundary by hunting control tokens, then decodes.
// Optional TMDS_ERR_CNT_EN adds a saturating symbol-error counter on err_cnt_o.
module tmds_decoder #(
   parameter int unsigned LOCK_CNT   = 8,
   parameter int unsigned SEARCH_LEN = 2048,
   parameter int unsigned LOSS_CNT   = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [9:0]  sym_i,
   output logic        de_o,
   output logic [7:0]  data_o,
   output logic [1:0]  ctrl_o,
   output logic        locked_o,
`ifdef TMDS_ERR_CNT_EN
   output logic [15:0] err_cnt_o,
`endif
   output logic [3:0]  offset_o
);

   localparam int unsigned RunW  = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT + 1) : 1;
   localparam int unsigned SrchW = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN)   : 1;
   localparam int unsigned LossW = (LOSS_CNT   > 1) ? $clog2(LOSS_CNT)     : 1;

   localparam logic [RunW-1:0]  RunLast  = RunW'(LOCK_CNT - 1);
   localparam logic [SrchW-1:0] SrchLast = SrchW'(SEARCH_LEN - 1);
   localparam logic [LossW-1:0] LossLast = LossW'(LOSS_CNT - 1);

   typedef enum logic [0:0] {StHunt, StLocked} state_e;

   state_e           state_q, state_d;
   logic [3:0]       offset_q, offset_d;
   logic [RunW-1:0]  run_q, run_d;
   logic [SrchW-1:0] srch_q, srch_d;
   logic [LossW-1:0] loss_q, loss_d;

   logic [9:0]  prev_q;
   logic [9:0]  win_q;
   logic [19:0] cat;
   logic [9:0]  win;

   logic        tok;
   logic [1:0]  tok_c;
   logic [7:0]  dec;
   logic        locked_d;

   logic        de_q;
   logic [7:0]  data_q;
   logic [1:0]  ctrl_q;

   function automatic logic [7:0] tmds_dec(input logic [9:0] s);
      logic [7:0] d;
      logic [7:0] q;
      d    = s[9] ? ~s[7:0] : s[7:0];
      q[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return q;
   endfunction

   // Window across the previous and current words; offset selects the first wire bit.
   always_comb begin
      cat = {sym_i, prev_q};
      win = cat[9:0];
      for (int k = 1; k < 10; k++) begin
         if (offset_q == 4'(k)) win = cat[k +: 10];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= '0;
         win_q  <= '0;
      end else begin
         prev_q <= sym_i;
         win_q  <= win;
      end
   end

   always_comb begin
      tok   = 1'b1;
      tok_c = 2'b00;
      case (win_q)
         10'b1101010100: tok_c = 2'b00;
         10'b0010101011: tok_c = 2'b01;
         10'b0101010100: tok_c = 2'b10;
         10'b1010101011: tok_c = 2'b11;
         default:        tok   = 1'b0;
      endcase
   end

   assign dec = tmds_dec(win_q);

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      run_d    = run_q;
      srch_d   = srch_q;
      loss_d   = loss_q;
      unique case (state_q)
         StHunt: begin
            loss_d = '0;
            // Lock takes priority over an offset advance landing on the same cycle.
            if (tok && (run_q >= RunLast)) begin
               state_d = StLocked;
               run_d   = '0;
               srch_d  = '0;
            end else if (srch_q >= SrchLast) begin
               offset_d = (offset_q >= 4'd9) ? 4'd0 : offset_q + 4'd1;
               run_d    = '0;
               srch_d   = '0;
            end else begin
               srch_d = srch_q + 1'b1;
               run_d  = tok ? run_q + 1'b1 : '0;
            end
         end
         StLocked: begin
            run_d  = '0;
            srch_d = '0;
            if (tok) begin
               loss_d = '0;
            end else if (loss_q >= LossLast) begin
               state_d = StHunt;
               loss_d  = '0;
            end else begin
               loss_d = loss_q + 1'b1;
            end
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StHunt;
         offset_q <= '0;
         run_q    <= '0;
         srch_q   <= '0;
         loss_q   <= '0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         run_q    <= run_d;
         srch_q   <= srch_d;
         loss_q   <= loss_d;
      end
   end

   // Gate on the next state so de drops on the same edge that leaves LOCKED.
   assign locked_d = (state_d == StLocked);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         de_q   <= 1'b0;
         data_q <= '0;
         ctrl_q <= '0;
      end else begin
         de_q   <= locked_d && !tok;
         data_q <= (locked_d && !tok) ? dec : 8'h00;
         if (tok) ctrl_q <= tok_c;
      end
   end

`ifdef TMDS_ERR_CNT_EN
   logic [15:0] err_q, err_d;
   logic [3:0]  ones;
   logic        sym_err;

   always_comb begin
      ones = '0;
      for (int k = 0; k < 8; k++) begin
         ones = ones + 4'(dec[k]);
      end
      // Imbalance |ones - zeros| > 4 means fewer than 2 or more than 6 ones.
      sym_err = !tok && ((win_q[9:8] == 2'b00) || (ones < 4'd2) || (ones > 4'd6));
      err_d   = err_q;
      if ((state_q == StLocked) && (state_d == StHunt)) begin
         err_d = '0;
      end else if ((state_q == StLocked) && sym_err && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= '0;
      else       err_q <= err_d;
   end

   assign err_cnt_o = err_q;
`endif

   assign de_o     = de_q;
   assign data_o   = data_q;
   assign ctrl_o   = ctrl_q;
   assign locked_o = (state_q == StLocked);
   assign offset_o = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: directed symbols, decoded bytes checked by a queue monitor.
// Define TMDS_ERR_CNT_EN to also exercise the error counter.
module tb_tmds_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] sym = '0;
   logic       de;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       locked;
   logic [3:0] offset;
`ifdef TMDS_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   bit mon_en = 1'b0;

   localparam logic [9:0] TOK00 = 10'h354;
   localparam logic [9:0] TOK01 = 10'h0AB;
   localparam logic [9:0] TOK10 = 10'h154;
   localparam logic [9:0] TOK11 = 10'h2AB;

   // Hand-decoded data symbols.
   logic [9:0] dsym [6] = '{10'h100, 10'h10F, 10'h30F, 10'h00F, 10'h200, 10'h1AA};
   logic [7:0] dexp [6] = '{8'h00,   8'h11,   8'h10,   8'hEF,   8'hFF,   8'hFE};
   logic [1:0] cexp [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};

   logic [9:0] t, prev_t;
   int  cyc;
   int  mon_line;
   bit  lock_seen, stop;

   always #5 clk = ~clk;

   tmds_decoder dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .sym_i     (sym),
      .de_o      (de),
      .data_o    (data),
      .ctrl_o    (ctrl),
      .locked_o  (locked),
`ifdef TMDS_ERR_CNT_EN
      .err_cnt_o (err_cnt),
`endif
      .offset_o  (offset)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic send(input logic [9:0] s);
      @(negedge clk);
      sym = s;
   endtask

   task automatic send_data(input int k, input bit push);
      send(dsym[k]);
      if (push) exp_q.push_back(dexp[k]);
   endtask

   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && de) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL data_unexpected: got %0h, want nothing queued", data);
            end else begin
               e = exp_q.pop_front();
               check("data_byte", 16'(data), 16'(e));
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_locked", 16'(locked), 16'd0);
      check("rst_de",     16'(de),     16'd0);
      check("rst_data",   16'(data),   16'd0);
      check("rst_ctrl",   16'(ctrl),   16'd0);
      check("rst_offset", 16'(offset), 16'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Aligned lock: output after send #m reflects symbol m-3
      repeat (8) send(TOK00);
      send_data(0, 1'b1);
      send_data(1, 1'b1);
      check("lock_early", 16'(locked), 16'd0);
      send_data(2, 1'b1);
      check("lock_set",   16'(locked), 16'd1);
      check("lock_ctrl",  16'(ctrl),   16'd0);
      check("lock_de_tok", 16'(de),    16'd0);
      send_data(3, 1'b1);
      check("first_de",   16'(de),     16'd1);
      check("first_data", 16'(data),   16'h00);
      send_data(4, 1'b1);
      send_data(5, 1'b1);

      // Control decode and hold
      send(TOK00);
      send(TOK01);
      send(TOK10);
      send(TOK11);
      check("ctrl_00", 16'(ctrl), 16'd0);
      for (int i = 0; i < 5; i++) begin
         send_data(i, 1'b1);
         check("ctrl_seq", 16'(ctrl), 16'(cexp[i]));
      end

      // Loss of lock after 4096 non-tokens
      send(TOK00);
      for (int k = 1; k <= 4099; k++) begin
         send_data(k % 6, k <= 4095);
         if (k == 4098) begin
            check("loss_pre_locked", 16'(locked), 16'd1);
            check("loss_pre_de",     16'(de),     16'd1);
         end
         if (k == 4099) begin
            check("loss_locked", 16'(locked), 16'd0);
            check("loss_de",     16'(de),     16'd0);
            check("loss_offset", 16'(offset), 16'd0);
         end
      end
      repeat (4) send(TOK00);
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      // Slip search: stream rotated by 3 bits, 800-clk lines of 64 tokens + data
      mon_en = 1'b0;
      do_reset();
      prev_t    = '0;
      cyc       = 0;
      lock_seen = 1'b0;
      stop      = 1'b0;
      mon_line  = 0;
      for (int ln = 0; ln < 14 && !stop; ln++) begin
         for (int i = 0; i < 800 && !stop; i++) begin
            t = (i < 64) ? TOK00 : dsym[i % 4];
            if (lock_seen && ln == mon_line && i == 10)     mon_en = 1'b1;
            if (lock_seen && ln == mon_line + 1 && i == 10) mon_en = 1'b0;
            send({t[6:0], prev_t[9:7]});
            if (lock_seen && ln == mon_line && i >= 64) exp_q.push_back(dexp[i % 4]);
            prev_t = t;
            cyc++;
            if (cyc == 1000) check("slip_off0", 16'(offset), 16'd0);
            if (cyc == 3000) check("slip_off1", 16'(offset), 16'd1);
            if (cyc == 5000) check("slip_off2", 16'(offset), 16'd2);
            if (!lock_seen && locked) begin
               lock_seen = 1'b1;
               mon_line  = ln + 1;
               check("slip_lock_offset", 16'(offset), 16'd3);
            end
            if (lock_seen && ln == mon_line + 1 && i == 20) begin
               check("slip_queue", 16'(exp_q.size()), 16'd0);
               check("pre_rst_locked", 16'(locked), 16'd1);
               check("pre_rst_offset", 16'(offset), 16'd3);
               // Mid-cycle async reset
               #2 rst = 1'b1;
               #1;
               check("async_locked", 16'(locked), 16'd0);
               check("async_de",     16'(de),     16'd0);
               check("async_data",   16'(data),   16'd0);
               check("async_ctrl",   16'(ctrl),   16'd0);
               check("async_offset", 16'(offset), 16'd0);
               repeat (3) @(negedge clk);
               check("rst_hold_locked", 16'(locked), 16'd0);
               check("rst_hold_offset", 16'(offset), 16'd0);
               rst  = 1'b0;
               stop = 1'b1;
            end
         end
      end
      if (!lock_seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL slip_lock: got no lock after %0d cycles, want lock at offset 3", cyc);
      end

`ifdef TMDS_ERR_CNT_EN
      mon_en = 1'b0;
      do_reset();
      repeat (8) send(TOK00);
      repeat (5) send(10'h000);
      repeat (3) send(10'h10F);
      check("err_five", err_cnt, 16'd5);
      repeat (4100) send(10'h10F);
      check("err_hunt_locked", 16'(locked), 16'd0);
      check("err_hunt_clear",  err_cnt,     16'd0);
`endif

      check("final_queue", 16'(exp_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
